pixel_compositor: RTL and testbench

//  Pipelined per-pixel colour compositor for the VGA path; parametrised successor to the single-ball mapper.

---
 rtl/pixel_compositor.sv | 187 ++++++++++++++++++
 tb/tb_pixel_compositor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// Pipelined per-pixel compositor: N priority sprites over a 1-bit tile map over a gradient.
// Hit/tile evaluation happens on the incoming pixel, ahead of the edge that updates sprites or tiles.
module pixel_compositor #(
  parameter int          N_SPRITES  = 4,
  parameter int          TILE_SHIFT = 4,
  parameter int          TILE_ROWS  = 30,
  parameter int          TILE_COLS  = 40,
  parameter logic [23:0] TILE_RGB   = 24'h555500
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic                            pix_valid,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic [N_SPRITES-1:0]            spr_en,
  input  logic [10*N_SPRITES-1:0]         spr_x,
  input  logic [10*N_SPRITES-1:0]         spr_y,
  input  logic [10*N_SPRITES-1:0]         spr_w,
  input  logic [10*N_SPRITES-1:0]         spr_h,
  input  logic [24*N_SPRITES-1:0]         spr_rgb,
  input  logic                            tile_we,
  input  logic [$clog2(TILE_ROWS)-1:0]    tile_row,
  input  logic [$clog2(TILE_COLS)-1:0]    tile_col,
  input  logic                            tile_din,
  output logic                            out_valid,
  output logic [7:0]                      Red,
  output logic [7:0]                      Green,
  output logic [7:0]                      Blue,
  output logic [$clog2(N_SPRITES):0]      hit_idx
);

  localparam int RW = $clog2(TILE_ROWS);
  localparam int CW = $clog2(TILE_COLS);
  localparam int IW = $clog2(N_SPRITES) + 1;
  localparam logic [IW-1:0] NO_HIT = IW'(N_SPRITES);

  logic [N_SPRITES-1:0]    act_en_q, act_en_d;
  logic [10*N_SPRITES-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [10*N_SPRITES-1:0] act_w_q, act_w_d, act_h_q, act_h_d;
  logic [24*N_SPRITES-1:0] act_rgb_q, act_rgb_d;
  logic [TILE_COLS-1:0]    tile_q [TILE_ROWS];
  logic [TILE_COLS-1:0]    tile_d [TILE_ROWS];

  logic            s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d, s1_tile_q, s1_tile_d;
  logic [IW-1:0]   s1_idx_q, s1_idx_d;
  logic [23:0]     s1_rgb_q, s1_rgb_d;
  logic [6:0]      s1_bx_q, s1_bx_d;
  logic            s2_valid_q, s2_valid_d;
  logic [IW-1:0]   s2_idx_q, s2_idx_d;
  logic [23:0]     s2_rgb_q, s2_rgb_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic [23:0]     out_rgb_q, out_rgb_d;

  logic [10:0] sx, sy, sw, sh, px, py;
  logic [9:0]  row_full, col_full;

  // Next-state for sprite set, tile map and the three pipeline register ranks.
  always_comb begin
    if (frame_start) begin
      act_en_d  = spr_en;
      act_x_d   = spr_x;
      act_y_d   = spr_y;
      act_w_d   = spr_w;
      act_h_d   = spr_h;
      act_rgb_d = spr_rgb;
    end else begin
      act_en_d  = act_en_q;
      act_x_d   = act_x_q;
      act_y_d   = act_y_q;
      act_w_d   = act_w_q;
      act_h_d   = act_h_q;
      act_rgb_d = act_rgb_q;
    end

    tile_d = tile_q;
    if (tile_we && (int'(tile_row) < TILE_ROWS) && (int'(tile_col) < TILE_COLS)) begin
      tile_d[tile_row][tile_col] = tile_din;
    end else begin
      tile_d[0] = tile_q[0];
    end

    // Walk from the lowest priority upward so the lowest hitting index is left standing.
    px = {1'b0, DrawX};
    py = {1'b0, DrawY};
    sx = 11'd0; sy = 11'd0; sw = 11'd0; sh = 11'd0;
    s1_hit_d = 1'b0;
    s1_idx_d = NO_HIT;
    s1_rgb_d = 24'h000000;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      sx = {1'b0, act_x_q[10*i +: 10]};
      sy = {1'b0, act_y_q[10*i +: 10]};
      sw = {1'b0, act_w_q[10*i +: 10]};
      sh = {1'b0, act_h_q[10*i +: 10]};
      if (act_en_q[i] && (px + sw >= sx) && (px <= sx + sw) &&
          (py + sh >= sy) && (py <= sy + sh)) begin
        s1_hit_d = 1'b1;
        s1_idx_d = IW'(i);
        s1_rgb_d = act_rgb_q[24*i +: 24];
      end else begin
        s1_hit_d = s1_hit_d;
      end
    end

    row_full = DrawY >> TILE_SHIFT;
    col_full = DrawX >> TILE_SHIFT;
    if ((row_full < 10'(TILE_ROWS)) && (col_full < 10'(TILE_COLS))) begin
      s1_tile_d = tile_q[row_full[RW-1:0]][col_full[CW-1:0]];
    end else begin
      s1_tile_d = 1'b0;
    end
    s1_valid_d = pix_valid;
    s1_bx_d    = DrawX[9:3];

    s2_valid_d = s1_valid_q;
    if (!s1_valid_q) begin
      s2_rgb_d = 24'h000000;
      s2_idx_d = NO_HIT;
    end else if (s1_hit_q) begin
      s2_rgb_d = s1_rgb_q;
      s2_idx_d = s1_idx_q;
    end else if (s1_tile_q) begin
      s2_rgb_d = TILE_RGB;
      s2_idx_d = NO_HIT;
    end else begin
      s2_rgb_d = {8'h00, 8'h00, 8'h7f - {1'b0, s1_bx_q}};
      s2_idx_d = NO_HIT;
    end

    out_valid_d = s2_valid_q;
    out_rgb_d   = s2_rgb_q;
    out_idx_d   = s2_idx_q;
  end

  // State update with synchronous reset of every rank, sprite set and tile map.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_en_q    <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_w_q     <= '0;
      act_h_q     <= '0;
      act_rgb_q   <= '0;
      tile_q      <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_tile_q   <= 1'b0;
      s1_idx_q    <= NO_HIT;
      s1_rgb_q    <= 24'h000000;
      s1_bx_q     <= 7'd0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= NO_HIT;
      s2_rgb_q    <= 24'h000000;
      out_valid_q <= 1'b0;
      out_idx_q   <= NO_HIT;
      out_rgb_q   <= 24'h000000;
    end else begin
      act_en_q    <= act_en_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_w_q     <= act_w_d;
      act_h_q     <= act_h_d;
      act_rgb_q   <= act_rgb_d;
      tile_q      <= tile_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_tile_q   <= s1_tile_d;
      s1_idx_q    <= s1_idx_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_bx_q     <= s1_bx_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      s2_rgb_q    <= s2_rgb_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Red       = out_rgb_q[23:16];
  assign Green     = out_rgb_q[15:8];
  assign Blue      = out_rgb_q[7:0];
  assign hit_idx   = out_idx_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: directed pixels push expectations, a monitor pops on out_valid.
module tb_pixel_compositor;

  logic        Clk = 1'b0;
  logic        Reset, frame_start, pix_valid, tile_we, tile_din;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  spr_en;
  logic [39:0] spr_x, spr_y, spr_w, spr_h;
  logic [95:0] spr_rgb;
  logic [4:0]  tile_row;
  logic [5:0]  tile_col;
  logic        out_valid;
  logic [7:0]  Red, Green, Blue;
  logic [2:0]  hit_idx;

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  idx;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pixel_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_rgb(spr_rgb), .tile_we(tile_we),
    .tile_row(tile_row), .tile_col(tile_col), .tile_din(tile_din),
    .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue), .hit_idx(hit_idx)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic [23:0] rgb, input logic [2:0] idx, input int id);
    exp_t e;
    e.rgb = rgb;
    e.idx = idx;
    e.id  = id;
    exp_q.push_back(e);
    DrawX = x;
    DrawY = y;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] w, input logic [9:0] h, input logic [23:0] rgb);
    spr_x[10*i +: 10]   = x;
    spr_y[10*i +: 10]   = y;
    spr_w[10*i +: 10]   = w;
    spr_h[10*i +: 10]   = h;
    spr_rgb[24*i +: 24] = rgb;
  endtask

  task automatic latch();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic check_blank(input int id);
    total++;
    if (out_valid !== 1'b0 || {Red, Green, Blue} !== 24'h000000 || hit_idx !== 3'd4) begin
      bad++;
      $display("FAIL blank_%0d: got v=%b rgb=%h idx=%0d, want v=0 rgb=000000 idx=4",
               id, out_valid, {Red, Green, Blue}, hit_idx);
    end
  endtask

  // Monitor: every valid output pops one expectation; idle cycles must be blanked.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pixel: got rgb=%h idx=%0d with no pixel pending",
                   {Red, Green, Blue}, hit_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({Red, Green, Blue} !== e.rgb || hit_idx !== e.idx) begin
            bad++;
            $display("FAIL pixel_%0d: got rgb=%h idx=%0d, want rgb=%h idx=%0d",
                     e.id, {Red, Green, Blue}, hit_idx, e.rgb, e.idx);
          end
        end
      end else begin
        total++;
        if ({Red, Green, Blue} !== 24'h000000 || hit_idx !== 3'd4) begin
          bad++;
          $display("FAIL idle_blank: got rgb=%h idx=%0d, want rgb=000000 idx=4",
                   {Red, Green, Blue}, hit_idx);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; tile_we = 1'b0; tile_din = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; tile_row = 5'd0; tile_col = 6'd0;
    spr_en = 4'b0000; spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_rgb = '0;
    repeat (3) tick();
    check_blank(0);
    Reset = 1'b0;
    tick();

    pix(10'd0, 10'd0, 24'h00007f, 3'd4, 1);
    drain();

    // Sprite hanging off the top-left corner, plus inclusive right edge and first miss.
    set_spr(0, 10'd5, 10'd5, 10'd8, 10'd8, 24'hff5500);
    spr_en = 4'b0001;
    latch();
    pix(10'd0,  10'd0,  24'hff5500, 3'd0, 2);
    pix(10'd13, 10'd13, 24'hff5500, 3'd0, 3);
    pix(10'd14, 10'd5,  24'h00007e, 3'd4, 4);
    drain();

    set_spr(0, 10'd100, 10'd100, 10'd4, 10'd4, 24'hff0000);
    set_spr(2, 10'd100, 10'd100, 10'd4, 10'd4, 24'h00ff00);
    spr_en = 4'b0101;
    latch();
    pix(10'd100, 10'd100, 24'hff0000, 3'd0, 5);
    spr_en = 4'b0100;
    latch();
    pix(10'd100, 10'd100, 24'h00ff00, 3'd2, 6);

    // Staged move without frame_start stays invisible until latched.
    set_spr(2, 10'd300, 10'd100, 10'd4, 10'd4, 24'h00ff00);
    pix(10'd100, 10'd100, 24'h00ff00, 3'd2, 7);
    pix(10'd300, 10'd100, 24'h00005a, 3'd4, 8);
    latch();
    pix(10'd300, 10'd100, 24'h00ff00, 3'd2, 9);
    pix(10'd100, 10'd100, 24'h000073, 3'd4, 10);

    // frame_start in the same cycle as a pixel: that pixel sees the old set.
    set_spr(2, 10'd500, 10'd100, 10'd4, 10'd4, 24'h00ff00);
    frame_start = 1'b1;
    pix(10'd300, 10'd100, 24'h00ff00, 3'd2, 11);
    frame_start = 1'b0;
    pix(10'd300, 10'd100, 24'h00005a, 3'd4, 12);
    pix(10'd500, 10'd100, 24'h00ff00, 3'd2, 13);
    spr_en = 4'b0000;
    latch();
    drain();

    tile_we = 1'b1; tile_row = 5'd2; tile_col = 6'd3; tile_din = 1'b1;
    tick();
    tile_we = 1'b0;
    pix(10'd48,   10'd32, 24'h555500, 3'd4, 14);
    pix(10'd63,   10'd47, 24'h555500, 3'd4, 15);
    pix(10'd47,   10'd32, 24'h00007a, 3'd4, 16);
    pix(10'd1023, 10'd600, 24'h000000, 3'd4, 17);

    // Tile write coincident with a lookup of the same cell returns the old value.
    tile_we = 1'b1; tile_row = 5'd0; tile_col = 6'd0; tile_din = 1'b1;
    pix(10'd0, 10'd0, 24'h00007f, 3'd4, 18);
    tile_we = 1'b0;
    pix(10'd0, 10'd0, 24'h555500, 3'd4, 19);
    drain();

    // Reset on the 2nd of 4 streamed pixels: first two are dropped, state is cleared.
    DrawX = 10'd48; DrawY = 10'd32; pix_valid = 1'b1;
    tick();
    DrawX = 10'd0; DrawY = 10'd0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_blank(1);
    pix(10'd0, 10'd0, 24'h00007f, 3'd4, 20);
    check_blank(2);
    pix(10'd48, 10'd32, 24'h000079, 3'd4, 21);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pixels still pending, want 0", exp_q.size());
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
